// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial add/subtract unit. One full-adder cell processes one operand
//   bit per clock, LSB first. The result is published all at once when the
//   last bit is processed, so s/cout/ovf never show partial results.
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin an operation (accepted only when not busy)
//   sub    in   0 = add, 1 = subtract (a - b)
//   a, b   in   WIDTH-bit operands
//   cin    in   carry-in, add mode only
//   busy   out  operation in progress (WIDTH cycles after the start edge)
//   done   out  one-cycle pulse, result valid
//   s      out  registered WIDTH-bit result
//   cout   out  carry-out (not-borrow in subtract mode)
//   ovf    out  two's-complement signed overflow
//
// State    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | processing bit cnt_q of the latched operands
// ST_DONE  | result just published; start here chains a new op

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_shift;

    // The single full-adder cell, always fed from the LSBs of the
    // operand shift registers.
    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // Sum bits enter at the MSB and move down, so after WIDTH steps bit 0
    // of the operands ends up in bit 0 of the sum register.
    generate
        if (WIDTH == 1) begin : g_one
            assign sum_shift = fa_sum;
        end else begin : g_many
            assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    // Subtract is a + ~b + 1: invert b and force carry-in.
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = sum_shift;
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    s_d     = sum_shift;
                    cout_d  = fa_carry;
                    // carry_q is the carry into the MSB at this step.
                    ovf_d   = carry_q ^ fa_carry;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
